// File: rtl/waffle_pkg.sv
// Shared types and helpers for the waffle column memory.
//   word_t      : one 32-bit image word
//   col_t       : one column at the default height (row r in element r)
//   mem_state_e : memory phase (host load, solver service, host drain)
//   in_range    : unsigned column-address bounds check
package waffle_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DEF_ROWS = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [DEF_ROWS-1:0] col_t;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DRAIN
  } mem_state_e;

  function automatic logic in_range(input word_t addr, input int unsigned cols);
    return addr < word_t'(cols);
  endfunction

endpackage

// File: rtl/waffle_rc_counter.sv
// Column-major row/column word counter.
//   clk   : clock
//   clear : synchronous clear to row 0 / col 0 (highest priority)
//   inc   : advance one word; the final word wraps back to 0/0
//   row   : current row index
//   col   : current column index
//   last  : current position is the final word (ROWS-1, COLS-1)
module waffle_rc_counter #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  localparam int unsigned CW  = $clog2(ROWS * COLS) + 1,
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned KW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [KW-1:0] col,
  output logic          last
);

  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          row_wrap;

  assign row_wrap = (row_q == CW'(ROWS - 1));
  assign last     = row_wrap && (col_q == CW'(COLS - 1));
  assign row      = row_q[RW-1:0];
  assign col      = col_q[KW-1:0];

  always_ff @(posedge clk) begin
    if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (row_wrap) begin
        row_q <= '0;
        col_q <= last ? '0 : col_q + CW'(1);
      end else begin
        row_q <= row_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/waffle_col_mem.sv
// Column-organised image memory serving waffle_solver.
// Host loads IMG_ROWS*IMG_COLS words column-major, the solver is started
// with a one-cycle pulse, reads two columns combinationally and writes one
// column per clock, then the image is drained back to the host.
//   clk, rst_n                    : clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_data     : host load word stream
//   solver_start                  : one-cycle pulse after the last load word
//   solver_complete               : solver done, move to drain
//   addr1/in_data1, addr2/in_data2: combinational column read ports
//   we/addr_write/write_data      : registered column write port
//   dr_valid/dr_ready/dr_data/dr_last : host drain word stream
//   addr_err                      : sticky out-of-range access flag
module waffle_col_mem
  import waffle_pkg::*;
#(
  parameter int unsigned IMG_ROWS = 4,
  parameter int unsigned IMG_COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_data,
  output logic                     solver_start,
  input  logic                     solver_complete,
  input  logic [31:0]              addr1,
  input  logic [31:0]              addr2,
  output logic [IMG_ROWS*32-1:0]   in_data1,
  output logic [IMG_ROWS*32-1:0]   in_data2,
  input  logic                     we,
  input  logic [31:0]              addr_write,
  input  logic [IMG_ROWS*32-1:0]   write_data,
  output logic                     dr_valid,
  input  logic                     dr_ready,
  output logic [31:0]              dr_data,
  output logic                     dr_last,
  output logic                     addr_err
);

  localparam int unsigned RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int unsigned KW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;

  typedef word_t [IMG_ROWS-1:0] col_w_t;

  col_w_t     mem [IMG_COLS];
  mem_state_e state_q;

  logic          ld_fire, dr_fire, serve_act;
  logic          rd1_ok, rd2_ok, wr_ok, wr_oor;
  logic [RW-1:0] ld_row, dr_row;
  logic [KW-1:0] ld_col, dr_col;
  logic          ld_last, dr_cnt_last;

  // Outputs are gated by rst_n so the ports go quiet during reset even
  // though state only updates on the clock edge.
  assign serve_act = rst_n && (state_q == SERVE);
  assign ld_ready  = rst_n && (state_q == LOAD);
  assign dr_valid  = rst_n && (state_q == DRAIN);
  assign ld_fire   = ld_valid && ld_ready;
  assign dr_fire   = dr_valid && dr_ready;
  assign dr_last   = dr_valid && dr_cnt_last;

  assign rd1_ok = serve_act && in_range(addr1, IMG_COLS);
  assign rd2_ok = serve_act && in_range(addr2, IMG_COLS);
  assign wr_ok  = serve_act && we && in_range(addr_write, IMG_COLS);
  assign wr_oor = we && !in_range(addr_write, IMG_COLS);

  // Reads see pre-edge contents, so a same-cycle read of addr_write
  // returns the old column.
  assign in_data1 = rd1_ok ? mem[addr1[KW-1:0]] : '0;
  assign in_data2 = rd2_ok ? mem[addr2[KW-1:0]] : '0;
  assign dr_data  = dr_valid ? mem[dr_col][dr_row] : '0;

  // Counters are held clear outside their own phase, which also covers
  // reset abandoning a partial load or drain.
  waffle_rc_counter #(.ROWS(IMG_ROWS), .COLS(IMG_COLS)) u_ld_cnt (
    .clk   (clk),
    .clear (!rst_n || (state_q != LOAD)),
    .inc   (ld_fire),
    .row   (ld_row),
    .col   (ld_col),
    .last  (ld_last)
  );

  waffle_rc_counter #(.ROWS(IMG_ROWS), .COLS(IMG_COLS)) u_dr_cnt (
    .clk   (clk),
    .clear (!rst_n || (state_q != DRAIN)),
    .inc   (dr_fire),
    .row   (dr_row),
    .col   (dr_col),
    .last  (dr_cnt_last)
  );

  // Storage has no reset; load and solver writes are phase-exclusive.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem[ld_col][ld_row] <= ld_data;
    end else if (wr_ok) begin
      mem[addr_write[KW-1:0]] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      solver_start <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      solver_start <= ld_fire && ld_last;
      case (state_q)
        LOAD: begin
          if (ld_fire && ld_last) state_q <= SERVE;
        end
        SERVE: begin
          if (!in_range(addr1, IMG_COLS) || !in_range(addr2, IMG_COLS) || wr_oor)
            addr_err <= 1'b1;
          if (solver_complete) state_q <= DRAIN;
        end
        DRAIN: begin
          if (dr_fire && dr_cnt_last) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_waffle_col_mem.sv
module tb_waffle_col_mem;

  localparam int unsigned R = 4;
  localparam int unsigned C = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_valid, ld_ready;
  logic [31:0]       ld_data;
  logic              solver_start, solver_complete;
  logic [31:0]       addr1, addr2, addr_write;
  logic [R*32-1:0]   in_data1, in_data2, write_data;
  logic              we;
  logic              dr_valid, dr_ready, dr_last, addr_err;
  logic [31:0]       dr_data;

  always #5 clk = ~clk;

  waffle_col_mem #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_data         (ld_data),
    .solver_start    (solver_start),
    .solver_complete (solver_complete),
    .addr1           (addr1),
    .addr2           (addr2),
    .in_data1        (in_data1),
    .in_data2        (in_data2),
    .we              (we),
    .addr_write      (addr_write),
    .write_data      (write_data),
    .dr_valid        (dr_valid),
    .dr_ready        (dr_ready),
    .dr_data         (dr_data),
    .dr_last         (dr_last),
    .addr_err        (addr_err)
  );

  typedef struct {
    logic [31:0]  a1;
    logic [31:0]  a2;
    logic         we;
    logic [31:0]  aw;
    logic [127:0] wd;
    logic [127:0] e1;
    logic [127:0] e2;
    logic         eerr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t         vt [8];
  logic [127:0] sbq [$];
  logic [31:0]  mm [C][R];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] colv(input logic [31:0] r0, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int           early;
    logic [127:0] e;
    logic [31:0]  held;
    bit           stalled;
    bit           done;

    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; solver_complete = 1'b0;
    addr1 = '0; addr2 = '0; we = 1'b0; addr_write = '0; write_data = '0;
    dr_ready = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_dr_valid", dr_valid, 0);
    chk("rst_dr_last", dr_last, 0);
    chk("rst_in_data1", in_data1, 0);
    chk("rst_solver_start", solver_start, 0);
    chk("rst_addr_err", addr_err, 0);
    rst_n = 1'b1;
    #1;
    chk("load_ready", ld_ready, 1);

    // Partial load abandoned by reset
    for (int k = 0; k < 7; k++) begin
      ld_valid = 1'b1; ld_data = 32'd100 + k;
      tick;
    end
    chk("partial_ready", ld_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", ld_ready, 0);
    tick;
    rst_n = 1'b1;

    // Fresh full load 1..16; a counter surviving reset would start early
    early = 0;
    for (int k = 0; k < 16; k++) begin
      ld_data = k + 1;
      mm[k / R][k % R] = k + 1;
      tick;
      if (k < 15 && solver_start) early++;
    end
    chk("start_early", early, 0);
    chk("start_pulse", solver_start, 1);
    ld_data = 32'hDEAD_BEEF;
    chk("serve_ld_ready", ld_ready, 0);
    tick;
    chk("start_one_cycle", solver_start, 0);

    // SERVE vectors; e1/e2 are pre-edge reads, eerr is addr_err before this edge
    vt[0] = '{32'd2, 32'd2, 1'b0, 32'd0, '0,
              colv(9,10,11,12), colv(9,10,11,12), 1'b0};
    vt[1] = '{32'd2, 32'd0, 1'b1, 32'd2, colv(0,0,0,7),
              colv(9,10,11,12), colv(1,2,3,4), 1'b0};
    vt[2] = '{32'd2, 32'd3, 1'b0, 32'd0, '0,
              colv(0,0,0,7), colv(13,14,15,16), 1'b0};
    vt[3] = '{32'd5, 32'd1, 1'b0, 32'd0, '0,
              '0, colv(5,6,7,8), 1'b0};
    vt[4] = '{32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, {4{32'hAAAA_AAAA}},
              colv(1,2,3,4), colv(5,6,7,8), 1'b1};
    vt[5] = '{32'd3, 32'd2, 1'b0, 32'd0, '0,
              colv(13,14,15,16), colv(0,0,0,7), 1'b1};
    vt[6] = '{32'd4, 32'h8000_0002, 1'b0, 32'd0, '0,
              '0, '0, 1'b1};
    vt[7] = '{32'd1, 32'd0, 1'b1, 32'd4, {4{32'hBBBB_BBBB}},
              colv(5,6,7,8), colv(1,2,3,4), 1'b1};

    for (int i = 0; i < 8; i++) begin
      addr1 = vt[i].a1; addr2 = vt[i].a2; we = vt[i].we;
      addr_write = vt[i].aw; write_data = vt[i].wd;
      sbq.push_back(vt[i].e1);
      sbq.push_back(vt[i].e2);
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_rd1", i), in_data1, e);
      e = sbq.pop_front();
      chk($sformatf("v%0d_rd2", i), in_data2, e);
      chk($sformatf("v%0d_err", i), addr_err, vt[i].eerr);
      tick;
    end
    mm[2][0] = 0; mm[2][1] = 0; mm[2][2] = 0; mm[2][3] = 7;

    // Completion cycle write must still land
    addr1 = 0; addr2 = 0; we = 1'b1; addr_write = 0; write_data = colv(5,5,5,5);
    solver_complete = 1'b1;
    #1;
    chk("complete_rd_old", in_data1, colv(1,2,3,4));
    tick;
    solver_complete = 1'b0;
    for (int r = 0; r < 4; r++) mm[0][r] = 5;

    // DRAIN: writes and reads must be ignored
    addr_write = 1; write_data = '1;
    #1;
    chk("drain_rd_zero", in_data1, 0);
    chk("drain_ld_ready", ld_ready, 0);
    chk("drain_valid", dr_valid, 1);

    for (int c = 0; c < int'(C); c++)
      for (int r = 0; r < int'(R); r++)
        sbq.push_back({96'd0, mm[c][r]});

    stalled = 1'b0; done = 1'b0; held = '0;
    for (int i = 0; i < 64 && !done; i++) begin
      dr_ready = (i % 3 != 1);
      #1;
      if (stalled) chk("dr_stable", dr_data, held);
      if (dr_ready) begin
        e = sbq.pop_front();
        chk("dr_data", dr_data, e);
        chk("dr_last", dr_last, sbq.size() == 0);
        if (sbq.size() == 0) begin
          done = 1'b1;
          ld_valid = 1'b0;
          we = 1'b0;
        end
        stalled = 1'b0;
      end else begin
        held = dr_data;
        stalled = 1'b1;
      end
      tick;
    end
    if (!done) chk("drain_timeout", 0, 1);
    dr_ready = 1'b0;

    chk("post_drain_ld_ready", ld_ready, 1);
    chk("post_drain_valid", dr_valid, 0);
    chk("err_sticky", addr_err, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    chk("err_cleared", addr_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waffle_col_mem.md
Name: waffle_col_mem

Overview:
- Column-organised image memory that acts as the responder for waffle_solver's memory interface.
- Provides two combinational read ports (addr1/addr2 to in_data1/in_data2) and one registered write port (we/addr_write/write_data).
- Loaded by a host word stream before the solve, hands control to the solver with a start pulse, and streams the (prefix-summed) image back to the host after solver completion.
- Sits between the host-side loader/unloader and waffle_solver.

Parameters:
- IMG_ROWS, 4, rows per column; each column is IMG_ROWS x 32 bits, row r at bits [r*32 +: 32].
- IMG_COLS, 4, number of columns; valid column addresses are 0..IMG_COLS-1.

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- ld_valid  in  1  host load word valid.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- ld_data  in  32  load word.
- solver_start  out  1  one-cycle pulse: image loaded, solver may run.
- solver_complete  in  1  solver's complete output.
- addr1  in  32  read port 1 column address.
- addr2  in  32  read port 2 column address.
- in_data1  out  IMG_ROWS*32  column at addr1.
- in_data2  out  IMG_ROWS*32  column at addr2.
- we  in  1  write enable.
- addr_write  in  32  write column address.
- write_data  in  IMG_ROWS*32  write column.
- dr_valid  out  1  drain word valid.
- dr_ready  in  1  host drain ready.
- dr_data  out  32  drain word.
- dr_last  out  1  final drain word.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset: rst_n low at a clk edge gives state LOAD, load/drain counters 0, addr_err 0, solver_start 0. Memory contents are not cleared.
- While rst_n is low: ld_ready=0, dr_valid=0, dr_last=0, in_data1/2=0.
- Reset mid-operation abandons any load, serve or drain immediately.
- States: LOAD, SERVE, DRAIN.
- LOAD:
  - ld_ready=1.
  - Each handshake writes ld_data to word k: col k/IMG_ROWS, row k%IMG_ROWS (column-major). Row counter wraps IMG_ROWS-1 to 0 and increments col.
  - On handshake of word IMG_ROWS*IMG_COLS-1: next state SERVE, solver_start=1 for exactly the following cycle.
- SERVE:
  - in_data1/in_data2 are combinational reads of mem[addr], zero latency.
  - Both ports may address the same column.
  - A write with we=1 updates mem at the clk edge. A same-cycle read of addr_write returns the old value; the solver's prefix pass depends on this.
  - Writes are honoured only in SERVE, including the cycle in which solver_complete=1.
  - solver_complete=1 gives next state DRAIN.
- Outside SERVE: in_data1/2=0 and we is ignored.
- Address range:
  - An address >= IMG_COLS (unsigned 32-bit compare) reads 0.
  - A write to such an address is dropped.
  - In SERVE, any out-of-range read (reads regardless of we) or out-of-range write with we=1 sets addr_err. addr_err clears only on reset.
- DRAIN:
  - dr_valid=1; dr_data = mem word at the drain counter, same column-major order, combinational.
  - Counter advances on dr_valid && dr_ready. Data is held stable while dr_ready=0.
  - dr_last=1 on word IMG_ROWS*IMG_COLS-1. Its handshake returns the block to LOAD with counters zeroed.
- ld_valid in SERVE/DRAIN is ignored (ld_ready=0). dr_ready outside DRAIN is ignored.
- Arithmetic: counters sized $clog2(IMG_ROWS*IMG_COLS)+1; no data arithmetic, values pass unmodified.

Decomposition:
- Package waffle_pkg:
  - word_t (32-bit)
  - col_t (IMG_ROWS x word_t packed)
  - mem_state_e {LOAD, SERVE, DRAIN}
  - function in_range(addr, IMG_COLS)
- Sub-module waffle_rc_counter:
  - Row/column counter with inc, clear, last outputs.
  - Instanced once for load and once for drain.

Test Plan (IMG_ROWS=4, IMG_COLS=4):
- Load words 1..16 back-to-back -> mem col0={1,2,3,4} (row0=1), col3={13,14,15,16}; solver_start high exactly one cycle, the cycle after word 16's handshake.
- SERVE, addr1=2, addr2=2 -> in_data1=in_data2={9,10,11,12} same cycle. Then we=1, addr_write=2, write_data={0,0,0,7}, addr1=2 same cycle -> in_data1 old {9,10,11,12}; next cycle {0,0,0,7}.
- SERVE, addr1=5, then we=1 addr_write=32'hFFFF_FFFF -> in_data1=0, memory unchanged, addr_err=1 and remains 1 until rst_n low.
- solver_complete=1 with we=1 addr_write=0 data={5,5,5,5} -> write lands. Drain with dr_ready toggling 1,0,1 -> dr_data stable while stalled; sequence 5,5,5,5,5,6,...; dr_last on the 16th word; then ld_ready=1.
- rst_n low for one cycle midway through load (after 7 words) -> LOAD, count 0. A fresh 16-word load is required before solver_start.
- ld_valid held high during SERVE/DRAIN -> no memory change, ld_ready=0.
